// File: rtl/ral_apb_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : ral_apb_pkg
// Description : Shared types and constants for the APB register slave:
//               transfer-tracking FSM state enum, register offsets and
//               CTRL/STATUS bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package ral_apb_pkg;

    // Transfer-tracking state. The register holds the APB phase that was
    // accepted at the previous clock edge.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // Register byte offsets
    localparam logic [3:0] c_OFF_CTRL   = 4'h0;
    localparam logic [3:0] c_OFF_DATA   = 4'h4;
    localparam logic [3:0] c_OFF_STATUS = 4'h8;
    localparam logic [3:0] c_OFF_TIMER  = 4'hC;

    // Word indices (byte offset >> 2), used by the address decoder
    localparam logic [1:0] c_WORD_CTRL   = c_OFF_CTRL[3:2];
    localparam logic [1:0] c_WORD_DATA   = c_OFF_DATA[3:2];
    localparam logic [1:0] c_WORD_STATUS = c_OFF_STATUS[3:2];
    localparam logic [1:0] c_WORD_TIMER  = c_OFF_TIMER[3:2];

    // CTRL bit positions
    localparam int c_CTRL_TMR_EN  = 0;
    localparam int c_CTRL_IRQ_EN  = 1;
    localparam int c_CTRL_TMR_CLR = 2;

    // STATUS bit positions
    localparam int c_STATUS_DONE    = 0;
    localparam int c_STATUS_CNT_LSB = 8;
    localparam int c_STATUS_CNT_MSB = 15;

endpackage : ral_apb_pkg
`default_nettype wire

// File: rtl/ral_apb_slave_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : ral_apb_slave_if
// Description : APB bus bundle for the register slave (no PREADY/PSLVERR,
//               zero-wait-state transfers) plus the slave interrupt line.
// Ports       : PSEL, PENABLE, PWRITE, PADDR[ADDR_W], PWDATA[DATA_W]
//               (master -> slave); PRDATA[DATA_W], irq (slave -> master).
// Revision    : 1.0 - initial release
// ============================================================================
interface ral_apb_slave_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              irq;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, irq
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, irq
    );
endinterface : ral_apb_slave_if
`default_nettype wire

// File: rtl/ral_apb_timer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : ral_apb_timer
// Description : 32-bit free-running cycle counter. Counts while en=1, wraps
//               0xFFFFFFFF->0, clr forces zero and wins over counting.
//               Instantiated by ral_apb_slave only when RAL_APB_TIMER_EN
//               is defined.
// Ports       : PCLK    - clock, rising edge
//               PRESETn - synchronous active-low reset
//               en      - count enable
//               clr     - synchronous clear (priority over en)
//               count   - current count value
// Revision    : 1.0 - initial release
// ============================================================================
module ral_apb_timer (
    input  wire logic        PCLK,
    input  wire logic        PRESETn,
    input  wire logic        en,
    input  wire logic        clr,
    output logic      [31:0] count
);
    logic [31:0] r_count;

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + 32'd1;
        end
    end

    assign count = r_count;
endmodule : ral_apb_timer
`default_nettype wire

// File: rtl/ral_apb_slave.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : ral_apb_slave
// Description : Zero-wait-state APB register slave with four 32-bit words:
//                 0x0 CTRL   [0] tmr_en, [1] irq_en, [2] tmr_clr (pulse)
//                 0x4 DATA   32-bit RW
//                 0x8 STATUS [0] done (sticky, W1C), [15:8] wr_cnt (RO)
//                 0xC TIMER  RO
//               irq is registered STATUS.done & CTRL.irq_en.
// Config      : define RAL_APB_TIMER_EN to build the TIMER counter; without
//               it TIMER reads 0 and tmr_en/tmr_clr have no effect.
// Ports       : PCLK    - clock, rising edge
//               PRESETn - synchronous active-low reset
//               bus     - ral_apb_slave_if.slave (APB signals, PRDATA, irq)
// Revision    : 1.0 - initial release
// ============================================================================
module ral_apb_slave
    import ral_apb_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  wire logic         PCLK,
    input  wire logic         PRESETn,
    ral_apb_slave_if.slave    bus
);

    // ------------------------------------------------------------------
    // Bus aliases
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [1:0]        w_word;

    assign w_addr  = bus.PADDR;
    assign w_wdata = bus.PWDATA;
    assign w_word  = w_addr[3:2];

    // ------------------------------------------------------------------
    // Transfer FSM
    // SETUP means a setup phase was accepted at the last edge, so the
    // current cycle is the bus access phase: writes commit at its end.
    // Read data is captured on the edge that accepts the setup phase so
    // PRDATA is stable for the whole access phase.
    // ------------------------------------------------------------------
    apb_state_e r_state;
    apb_state_e w_state_nxt;
    logic       w_setup_acc;
    logic       w_wr_en;
    logic       w_rd_load;

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_setup_acc = 1'b0;
        case (r_state)
            IDLE: begin
                // PENABLE without a preceding setup is ignored here
                if (bus.PSEL && !bus.PENABLE) begin
                    w_state_nxt = SETUP;
                    w_setup_acc = 1'b1;
                end
            end
            SETUP: begin
                w_state_nxt = ACCESS;
            end
            ACCESS: begin
                if (bus.PSEL && !bus.PENABLE) begin
                    w_state_nxt = SETUP;
                    w_setup_acc = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_wr_en   = (r_state == SETUP) && bus.PSEL && bus.PENABLE && bus.PWRITE;
    assign w_rd_load = w_setup_acc && !bus.PWRITE;

    // ------------------------------------------------------------------
    // Write decode
    // ------------------------------------------------------------------
    logic w_wr_ctrl;
    logic w_wr_data;
    logic w_wr_status;
    logic w_tmr_clr;

    assign w_wr_ctrl   = w_wr_en && (w_word == c_WORD_CTRL);
    assign w_wr_data   = w_wr_en && (w_word == c_WORD_DATA);
    assign w_wr_status = w_wr_en && (w_word == c_WORD_STATUS);
    // tmr_clr is never stored; it only exists as this one-cycle pulse
    assign w_tmr_clr   = w_wr_ctrl && w_wdata[c_CTRL_TMR_CLR];

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic              r_tmr_en;
    logic              r_irq_en;
    logic [DATA_W-1:0] r_data;
    logic              r_done;
    logic [7:0]        r_cnt;
    logic              r_irq;
    logic [DATA_W-1:0] r_prdata;

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_tmr_en <= 1'b0;
            r_irq_en <= 1'b0;
        end else if (w_wr_ctrl) begin
            r_tmr_en <= w_wdata[c_CTRL_TMR_EN];
            r_irq_en <= w_wdata[c_CTRL_IRQ_EN];
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_data <= '0;
        end else if (w_wr_data) begin
            r_data <= w_wdata;
        end
    end

    // A DATA write setting done takes priority over a W1C clear.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_done <= 1'b0;
            r_cnt  <= 8'd0;
        end else begin
            if (w_wr_data) begin
                r_done <= 1'b1;
            end else if (w_wr_status && w_wdata[c_STATUS_DONE]) begin
                r_done <= 1'b0;
            end
            if (w_wr_data) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_done && r_irq_en;
        end
    end

    // ------------------------------------------------------------------
    // Optional timer
    // ------------------------------------------------------------------
    logic [31:0] w_timer;

`ifdef RAL_APB_TIMER_EN
    ral_apb_timer u_timer (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .en      (r_tmr_en),
        .clr     (w_tmr_clr),
        .count   (w_timer)
    );
`else
    logic w_unused_tmr;
    assign w_timer      = 32'd0;
    assign w_unused_tmr = w_tmr_clr;
`endif

    // Byte lanes below bit 2 and address bits above 3 do not affect decode
    logic w_unused_addr;
    assign w_unused_addr = ^w_addr;

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_rdata;

    always_comb begin
        w_rdata = '0;
        case (w_word)
            c_WORD_CTRL: begin
                w_rdata[c_CTRL_TMR_EN] = r_tmr_en;
                w_rdata[c_CTRL_IRQ_EN] = r_irq_en;
            end
            c_WORD_DATA: begin
                w_rdata = r_data;
            end
            c_WORD_STATUS: begin
                w_rdata[c_STATUS_DONE]                     = r_done;
                w_rdata[c_STATUS_CNT_MSB:c_STATUS_CNT_LSB] = r_cnt;
            end
            c_WORD_TIMER: begin
                w_rdata = w_timer;
            end
            default: begin
                w_rdata = '0;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_prdata <= '0;
        end else if (w_rd_load) begin
            r_prdata <= w_rdata;
        end
    end

    assign bus.PRDATA = r_prdata;
    assign bus.irq    = r_irq;

endmodule : ral_apb_slave
`default_nettype wire

// File: tb/tb_ral_apb_slave.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ral_apb_slave
// Description : Self-checking bench for ral_apb_slave. A small register model
//               predicts read data; expected words are queued when a read is
//               issued and compared when PRDATA is valid in the access phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ral_apb_slave;

    logic PCLK    = 1'b0;
    logic PRESETn = 1'b0;

    ral_apb_slave_if #(.ADDR_W(4), .DATA_W(32)) bus ();

    ral_apb_slave #(.ADDR_W(4), .DATA_W(32)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    always #5 PCLK = ~PCLK;

    int total = 0;
    int bad   = 0;

    logic [31:0] sb[$];
    logic [31:0] last_rd;
    logic [31:0] v;

    // Register model
    logic        m_tmr_en;
    logic        m_irq_en;
    logic        m_done;
    logic [7:0]  m_cnt;
    logic [31:0] m_data;

    function automatic logic [31:0] model_read(input logic [3:0] a);
        logic [31:0] r;
        r = 32'h0;
        case (a[3:2])
            2'd0: r = {30'h0, m_irq_en, m_tmr_en};
            2'd1: r = m_data;
            2'd2: r = {16'h0, m_cnt, 7'h0, m_done};
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        m_tmr_en = 1'b0;
        m_irq_en = 1'b0;
        m_done   = 1'b0;
        m_cnt    = 8'd0;
        m_data   = 32'h0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        repeat (n) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b1;
        bus.PADDR   = a;
        bus.PWDATA  = d;
        @(posedge PCLK);
        #1;
        bus.PENABLE = 1'b1;
        @(posedge PCLK);
        #1;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        case (a[3:2])
            2'd0: begin
                m_tmr_en = d[0];
                m_irq_en = d[1];
            end
            2'd1: begin
                m_data = d;
                m_done = 1'b1;
                m_cnt  = m_cnt + 8'd1;
            end
            2'd2: begin
                if (d[0]) m_done = 1'b0;
            end
            default: ;
        endcase
    endtask

    // Read with scoreboard: expectation queued at issue, compared in access phase
    task automatic rd(input string tag, input logic [3:0] a);
        logic [31:0] exp;
        sb.push_back(model_read(a));
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
        bus.PADDR   = a;
        @(posedge PCLK);
        #1;
        bus.PENABLE = 1'b1;
        exp = sb.pop_front();
        check(tag, bus.PRDATA, exp);
        last_rd = exp;
        @(posedge PCLK);
        #1;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
    endtask

    // Read returning the raw value (for the free-running timer)
    task automatic rd_raw(input logic [3:0] a, output logic [31:0] val);
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
        bus.PADDR   = a;
        @(posedge PCLK);
        #1;
        bus.PENABLE = 1'b1;
        val = bus.PRDATA;
        @(posedge PCLK);
        #1;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
    endtask

    task automatic do_reset();
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        PRESETn     = 1'b0;
        repeat (2) @(posedge PCLK);
        #1;
        PRESETn = 1'b1;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
        bus.PADDR   = 4'h0;
        bus.PWDATA  = 32'h0;
        model_reset();
        repeat (3) @(posedge PCLK);
        #1;
        PRESETn = 1'b1;

        // Reset state
        check("rst_prdata", bus.PRDATA, 32'h0);
        check("rst_irq", {31'h0, bus.irq}, 32'h0);
        rd("rst_ctrl", 4'h0);
        rd("rst_data", 4'h4);
        rd("rst_status", 4'h8);
        rd("rst_timer", 4'hC);

        // DATA write / readback, STATUS done + count
        wr(4'h4, 32'hA5A5_5A5A);
        rd("data_rb", 4'h4);
        rd("status_after_wr", 4'h8);
        idle(2);
        check("prdata_hold", bus.PRDATA, last_rd);

        // Back-to-back write then read, no idle cycle between
        wr(4'h4, 32'h1234_5678);
        rd("b2b_data", 4'h4);
        // Byte-lane address bits ignored
        rd("data_unaligned", 4'h7);

        // CTRL: only bits [1:0] stick, tmr_clr self-clears
        wr(4'h0, 32'hFFFF_FFFF);
        rd("ctrl_rb", 4'h0);

        // irq = done & irq_en, registered; falls one cycle after W1C
        wr(4'h0, 32'h0000_0002);
        idle(1);
        check("irq_high", {31'h0, bus.irq}, 32'h1);
        wr(4'h8, 32'h0000_0001);
        check("irq_still_high", {31'h0, bus.irq}, 32'h1);
        idle(1);
        check("irq_fell", {31'h0, bus.irq}, 32'h0);
        rd("status_w1c", 4'h8);

        // Write count wraps after 256 DATA writes in total (2 so far)
        for (int i = 0; i < 254; i++) wr(4'h4, i);
        rd("status_wrap", 4'h8);
        idle(1);
        check("irq_rise", {31'h0, bus.irq}, 32'h1);

        // W1C writing 0 keeps done; RO count unaffected by writes
        wr(4'h8, 32'h0000_0000);
        rd("status_w0", 4'h8);
        wr(4'h8, 32'hFFFF_FFFF);
        rd("status_w1_all", 4'h8);

        // TIMER ignores writes
        wr(4'hC, 32'hDEAD_BEEF);
        rd("data_after_timer_wr", 4'h4);

        do_reset();
`ifdef RAL_APB_TIMER_EN
        wr(4'h0, 32'h0000_0001);
        idle(10);
        rd_raw(4'hC, v);
        total++;
        assert (v >= 32'd10 && v <= 32'd12) else begin
            bad++;
            $error("FAIL timer_run observed=%0d expected=10..12", v);
        end
        wr(4'h0, 32'h0000_0005);
        rd_raw(4'hC, v);
        total++;
        assert (v <= 32'd1) else begin
            bad++;
            $error("FAIL timer_clr observed=%0d expected=0..1", v);
        end
        rd("ctrl_tmr", 4'h0);
`else
        wr(4'h0, 32'h0000_0001);
        idle(10);
        rd("timer_zero", 4'hC);
        wr(4'h0, 32'h0000_0005);
        rd("ctrl_tmr", 4'h0);
        rd("timer_zero2", 4'hC);
`endif

        // Reset asserted on the access edge of a DATA write
        wr(4'h4, 32'h0000_0055);
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b1;
        bus.PADDR   = 4'h4;
        bus.PWDATA  = 32'h0000_0077;
        @(posedge PCLK);
        #1;
        bus.PENABLE = 1'b1;
        PRESETn     = 1'b0;
        @(posedge PCLK);
        #1;
        PRESETn     = 1'b1;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        model_reset();
        rd("data_rst_access", 4'h4);
        rd("status_rst_access", 4'h8);

        // Reset on the setup edge, then an access phase without accepted setup
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b1;
        bus.PADDR   = 4'h4;
        bus.PWDATA  = 32'h0000_0066;
        PRESETn     = 1'b0;
        @(posedge PCLK);
        #1;
        PRESETn     = 1'b1;
        bus.PENABLE = 1'b1;
        @(posedge PCLK);
        #1;
        idle(1);
        rd("data_rst_setup", 4'h4);

        // PENABLE=1 with no setup phase must not write
        wr(4'h4, 32'h0000_1111);
        idle(1);
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b1;
        bus.PWRITE  = 1'b1;
        bus.PADDR   = 4'h4;
        bus.PWDATA  = 32'h0000_9999;
        @(posedge PCLK);
        #1;
        idle(2);
        rd("data_no_setup", 4'h4);
        rd("status_no_setup", 4'h8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_ral_apb_slave
`default_nettype wire
